// File: rtl/mips_harvard_avalon_bridge.sv
// Bridges a Harvard-interface MIPS core onto one Avalon-MM bus: one instruction fetch,
// then at most one data access per core step, with the core held until both finish.
module mips_harvard_avalon_bridge #(
   parameter int SKIP_REFETCH = 1,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_active,
   output logic        cpu_clk_enable,
   input  logic [31:0] cpu_instr_address,
   output logic [31:0] cpu_instr_readdata,
   input  logic [31:0] cpu_data_address,
   input  logic        cpu_data_read,
   input  logic        cpu_data_write,
   input  logic [31:0] cpu_data_writedata,
   output logic [31:0] cpu_data_readdata,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        err_misaligned,
   output logic        err_timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IFETCH  = 2'd1,
      DACCESS = 2'd2,
      STEP    = 2'd3
   } state_t;

   // The abort fires in the cycle whose wait would bring the count up to WAIT_TIMEOUT.
   localparam logic [7:0] TIMEOUT_LAST = 8'(WAIT_TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic [7:0]  wait_cnt;
   logic [31:0] tag_addr;
   logic        tag_valid;
   logic        tag_hit;
   logic        data_req;
   logic        strobe;
   logic        bus_done;
   logic        bus_abort;
   logic        xfer_end;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   assign data_req = cpu_data_read | cpu_data_write;
   assign tag_hit  = (SKIP_REFETCH != 0) && tag_valid && (tag_addr == cpu_instr_address);

   // Bus strobes follow the state directly; the core is stalled, so its address and
   // data inputs remain stable for as long as waitrequest holds the transfer.
   always_comb begin
      avm_address    = 32'h0;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_writedata  = 32'h0;
      avm_byteenable = 4'b0000;
      case (state)
         IFETCH: begin
            avm_address    = word_align(cpu_instr_address);
            avm_read       = 1'b1;
            avm_byteenable = 4'b1111;
         end
         DACCESS: begin
            avm_address    = word_align(cpu_data_address);
            avm_byteenable = 4'b1111;
            if (cpu_data_write) begin
               avm_write     = 1'b1;
               avm_writedata = cpu_data_writedata;
            end else if (cpu_data_read) begin
               avm_read = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   assign strobe    = avm_read | avm_write;
   assign bus_done  = strobe & ~avm_waitrequest;
   assign bus_abort = strobe & avm_waitrequest & (wait_cnt == TIMEOUT_LAST);
   assign xfer_end  = bus_done | bus_abort | ~strobe;

   assign cpu_clk_enable = (state == STEP);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (cpu_active) begin
               if (tag_hit)
                  state_next = data_req ? DACCESS : STEP;
               else
                  state_next = IFETCH;
            end
         end
         IFETCH: begin
            if (xfer_end)
               state_next = data_req ? DACCESS : STEP;
         end
         DACCESS: begin
            if (xfer_end)
               state_next = STEP;
         end
         STEP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Counts consecutive stalled cycles of the current transfer only.
   always_ff @(posedge clk) begin
      if (reset)
         wait_cnt <= 8'h00;
      else if (strobe && avm_waitrequest && !bus_abort)
         wait_cnt <= wait_cnt + 8'h01;
      else
         wait_cnt <= 8'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_instr_readdata <= 32'h0;
         tag_addr           <= 32'h0;
         tag_valid          <= 1'b0;
      end else if (state == IFETCH) begin
         if (bus_done) begin
            cpu_instr_readdata <= avm_readdata;
            tag_addr           <= cpu_instr_address;
            tag_valid          <= 1'b1;
         end else if (bus_abort) begin
            cpu_instr_readdata <= 32'h0;
            tag_valid          <= 1'b0;
         end
      end else if (state == DACCESS && avm_write) begin
         // A store may have overwritten the cached instruction word.
         tag_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_data_readdata <= 32'h0;
      end else if (state == DACCESS && avm_read) begin
         if (bus_done)
            cpu_data_readdata <= avm_readdata;
         else if (bus_abort)
            cpu_data_readdata <= 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_misaligned <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         if (state == DACCESS && data_req && cpu_data_address[1:0] != 2'b00)
            err_misaligned <= 1'b1;
         if (bus_abort)
            err_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_harvard_avalon_bridge.sv
// Scoreboard bench for mips_harvard_avalon_bridge: directed core steps against a
// reactive Avalon slave with programmable waitrequest.
module tb_mips_harvard_avalon_bridge;
   localparam int TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_active = 1'b0;
   logic        cpu_clk_enable;
   logic [31:0] cpu_instr_address = 32'h0;
   logic [31:0] cpu_instr_readdata;
   logic [31:0] cpu_data_address = 32'h0;
   logic        cpu_data_read = 1'b0;
   logic        cpu_data_write = 1'b0;
   logic [31:0] cpu_data_writedata = 32'h0;
   logic [31:0] cpu_data_readdata;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata = 32'h0;
   logic        avm_waitrequest = 1'b0;
   logic        err_misaligned;
   logic        err_timeout;

   mips_harvard_avalon_bridge #(.SKIP_REFETCH(1), .WAIT_TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .cpu_active(cpu_active), .cpu_clk_enable(cpu_clk_enable),
      .cpu_instr_address(cpu_instr_address), .cpu_instr_readdata(cpu_instr_readdata),
      .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
      .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
      .cpu_data_readdata(cpu_data_readdata), .avm_address(avm_address),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
      .avm_waitrequest(avm_waitrequest), .err_misaligned(err_misaligned),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        abort;
      logic        last;
   } bus_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] data;
      int          lat;
   } step_t;

   bus_t  bus_q[$];
   step_t step_q[$];
   int    checks = 0;
   int    errors = 0;
   int    wait_n = 0;
   int    cyc = 0;
   bit    step_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      case (a)
         32'hBFC00000: return 32'h24020005;
         32'h00001004: return 32'hDEADBEEF;
         32'h00001000: return 32'hCAFEF00D;
         default:      return a ^ 32'hA5A5A5A5;
      endcase
   endfunction

   // Avalon slave: stalls each new transfer for wait_n cycles.
   int sl_cnt = 0;
   bit sl_done = 0;
   always @(negedge clk) begin
      if (!(avm_read || avm_write) || sl_done) sl_cnt = 0;
      sl_done = 0;
      if (avm_read || avm_write) begin
         if (sl_cnt < wait_n) begin
            avm_waitrequest = 1'b1;
            sl_cnt++;
         end else begin
            avm_waitrequest = 1'b0;
            sl_done = 1;
         end
      end else begin
         avm_waitrequest = 1'b0;
      end
      avm_readdata = mem_rd(avm_address);
   end

   // Bus monitor: compares each completed or aborted transfer with the queue.
   int          tb_wcnt = 0;
   bit          hold_chk = 0;
   bit          drop_chk = 0;
   logic [31:0] h_addr, h_wdata;
   logic        h_rd, h_wr;
   logic [3:0]  h_be;

   task automatic bus_pop(input logic abort);
      bus_t e;
      if (bus_q.size() == 0) begin
         chk("bus_unexpected", avm_address, 32'hFFFFFFFF);
      end else begin
         e = bus_q.pop_front();
         chk("bus_write", avm_write, e.wr);
         chk("bus_read", avm_read, !e.wr);
         chk("bus_addr", avm_address, e.addr);
         chk("bus_be", avm_byteenable, 4'b1111);
         if (e.wr) chk("bus_wdata", avm_writedata, e.wdata);
         chk("bus_abort", abort, e.abort);
         drop_chk = e.last;
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (reset) begin
         tb_wcnt = 0; hold_chk = 0; drop_chk = 0;
      end else begin
         if (avm_read && avm_write) chk("rd_wr_both", 1'b1, 1'b0);
         if (hold_chk) begin
            chk("hold_addr", avm_address, h_addr);
            chk("hold_rd", avm_read, h_rd);
            chk("hold_wr", avm_write, h_wr);
            chk("hold_wdata", avm_writedata, h_wdata);
            chk("hold_be", avm_byteenable, h_be);
         end
         if (drop_chk) chk("strobe_drop", avm_read | avm_write, 1'b0);
         hold_chk = 0;
         drop_chk = 0;
         if (avm_read || avm_write) begin
            if (!avm_waitrequest) begin
               bus_pop(1'b0);
               tb_wcnt = 0;
            end else begin
               tb_wcnt++;
               if (tb_wcnt == TB_TIMEOUT) begin
                  bus_pop(1'b1);
                  tb_wcnt = 0;
               end else begin
                  hold_chk = 1;
                  h_addr = avm_address; h_rd = avm_read; h_wr = avm_write;
                  h_wdata = avm_writedata; h_be = avm_byteenable;
               end
            end
         end else begin
            tb_wcnt = 0;
         end
      end
   end

   // Step monitor: each cpu_clk_enable pulse must match one queued step.
   always @(negedge clk) begin
      step_t e;
      #1;
      if (cpu_clk_enable) begin
         if (step_q.size() == 0) begin
            chk("step_unexpected", 32'd1, 32'd0);
         end else begin
            e = step_q.pop_front();
            chk("instr_readdata", cpu_instr_readdata, e.instr);
            chk("data_readdata", cpu_data_readdata, e.data);
            chk("step_latency", cyc, e.lat);
         end
         step_done = 1;
      end
      cyc++;
   end

   task automatic push_bus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic abort, input logic last);
      bus_q.push_back('{wr, addr, wd, abort, last});
   endtask

   task automatic do_step(input logic [31:0] ia, input logic rd, input logic wr,
                          input logic [31:0] da, input logic [31:0] wd, input int wn,
                          input logic [31:0] ei, input logic [31:0] ed, input int lat);
      int n;
      step_q.push_back('{ei, ed, lat});
      cpu_instr_address  = ia;
      cpu_data_read      = rd;
      cpu_data_write     = wr;
      cpu_data_address   = da;
      cpu_data_writedata = wd;
      wait_n             = wn;
      cyc                = 0;
      step_done          = 0;
      cpu_active         = 1'b1;
      n = 0;
      while (!step_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!step_done) chk("step_wait_bound", 32'd0, 32'd1);
      cpu_active     = 1'b0;
      cpu_data_read  = 1'b0;
      cpu_data_write = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_clk_en"}, cpu_clk_enable, 1'b0);
      chk({tag, "_avm_read"}, avm_read, 1'b0);
      chk({tag, "_avm_write"}, avm_write, 1'b0);
      chk({tag, "_avm_addr"}, avm_address, 32'h0);
      chk({tag, "_avm_wdata"}, avm_writedata, 32'h0);
      chk({tag, "_avm_be"}, avm_byteenable, 4'h0);
      chk({tag, "_instr"}, cpu_instr_readdata, 32'h0);
      chk({tag, "_data"}, cpu_data_readdata, 32'h0);
      chk({tag, "_misaligned"}, err_misaligned, 1'b0);
      chk({tag, "_timeout"}, err_timeout, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Fetch only
      push_bus(1'b0, 32'hBFC00000, 32'h0, 1'b0, 1'b1);
      do_step(32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h24020005, 32'h0, 2);

      // Load on a tag hit with three stall cycles
      push_bus(1'b0, 32'h00001004, 32'h0, 1'b0, 1'b1);
      do_step(32'hBFC00000, 1'b1, 1'b0, 32'h00001004, 32'h0, 3, 32'h24020005, 32'hDEADBEEF, 5);

      // Store invalidates the tag, so the next step refetches
      push_bus(1'b1, 32'h00000010, 32'h12345678, 1'b0, 1'b1);
      do_step(32'hBFC00000, 1'b0, 1'b1, 32'h00000010, 32'h12345678, 0, 32'h24020005, 32'hDEADBEEF, 2);
      push_bus(1'b0, 32'hBFC00000, 32'h0, 1'b0, 1'b1);
      do_step(32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h24020005, 32'hDEADBEEF, 2);

      // Tag hits with no data access: no bus traffic
      for (int i = 0; i < 2; i++)
         do_step(32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h24020005, 32'hDEADBEEF, 1);

      // Read and write together: write wins, load data untouched
      push_bus(1'b1, 32'h00000020, 32'hAABBCCDD, 1'b0, 1'b1);
      do_step(32'hBFC00000, 1'b1, 1'b1, 32'h00000020, 32'hAABBCCDD, 0, 32'h24020005, 32'hDEADBEEF, 2);
      chk("misaligned_before", err_misaligned, 1'b0);

      // Misaligned load after refetch, then sticky across ten steps
      push_bus(1'b0, 32'hBFC00000, 32'h0, 1'b0, 1'b0);
      push_bus(1'b0, 32'h00001000, 32'h0, 1'b0, 1'b1);
      do_step(32'hBFC00000, 1'b1, 1'b0, 32'h00001002, 32'h0, 0, 32'h24020005, 32'hCAFEF00D, 3);
      chk("misaligned_set", err_misaligned, 1'b1);
      for (int i = 0; i < 10; i++)
         do_step(32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h24020005, 32'hCAFEF00D, 1);
      chk("misaligned_sticky", err_misaligned, 1'b1);
      chk("timeout_before", err_timeout, 1'b0);

      // Stuck waitrequest aborts the fetch
      push_bus(1'b0, 32'h00000100, 32'h0, 1'b1, 1'b1);
      do_step(32'h00000100, 1'b0, 1'b0, 32'h0, 32'h0, 1000, 32'h0, 32'hCAFEF00D, 5);
      chk("timeout_set", err_timeout, 1'b1);

      // Reset in the middle of a stalled fetch
      cpu_instr_address = 32'h00000200;
      wait_n = 1000;
      cpu_active = 1'b1;
      repeat (3) @(negedge clk);
      chk("midwait_read", avm_read, 1'b1);
      chk("midwait_addr", avm_address, 32'h00000200);
      reset = 1'b1;
      cpu_active = 1'b0;
      @(negedge clk);
      #2;
      chk_outputs_zero("midreset");
      reset = 1'b0;
      @(negedge clk);

      // Reset also invalidated the tag
      push_bus(1'b0, 32'hBFC00000, 32'h0, 1'b0, 1'b1);
      do_step(32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h24020005, 32'h0, 2);

      repeat (3) @(negedge clk);
      chk("bus_q_left", bus_q.size(), 32'd0);
      chk("step_q_left", step_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

endmodule
